// File: rtl/instruction_cache_unit_pkg.sv
// Shared constants for the instruction cache.
// Geometry: direct-mapped, 8 blocks of 128 bits (four 32-bit words) over a
// 1 KB instruction space. Also defines the cache controller state encoding.
package instruction_cache_unit_pkg;

    localparam int TAG_W      = 3;
    localparam int INDEX_W    = 3;
    localparam int WORD_SEL_W = 2;
    localparam int BLOCK_W    = 128;
    localparam int NUM_BLOCKS = 8;
    localparam int MEM_ADDR_W = 6;
    localparam int WORD_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_READ = 2'd1,
        ST_UPDATE   = 2'd2
    } state_t;

endpackage

// File: rtl/instruction_cache_unit_if.sv
// Bus bundle between CPU fetch stage, instruction cache and instruction memory.
//   ADDRESS      CPU -> cache   instruction byte address
//   INSTRUCTION  cache -> CPU   fetched word, meaningful only when BUSYWAIT=0
//   BUSYWAIT     cache -> CPU   stall; CPU holds ADDRESS stable while high
//   MEM_READ     cache -> mem   block read request
//   MEM_ADDRESS  cache -> mem   block address {tag, index}
//   MEM_READDATA mem -> cache   16-byte block, word 0 in bits [31:0]
//   MEM_BUSYWAIT mem -> cache   high while busy; low means MEM_READDATA is valid
// Handshake: a request is MEM_READ held high with a stable MEM_ADDRESS; it
// completes on the first rising edge where MEM_BUSYWAIT is low. On the CPU
// side BUSYWAIT is the inverse of "ready": INSTRUCTION is consumed only on an
// edge where BUSYWAIT is low.
// Modports: slave = cache side, master = CPU/memory environment side.
interface instruction_cache_unit_if;

    logic [31:0]                                        ADDRESS;
    logic [31:0]                                        INSTRUCTION;
    logic                                               BUSYWAIT;
    logic                                               MEM_READ;
    logic [instruction_cache_unit_pkg::MEM_ADDR_W-1:0]  MEM_ADDRESS;
    logic [instruction_cache_unit_pkg::BLOCK_W-1:0]     MEM_READDATA;
    logic                                               MEM_BUSYWAIT;

    modport slave (
        input  ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
        output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );

    modport master (
        output ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
        input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );

endinterface

// File: rtl/icache_word_select.sv
// Selects one 32-bit word out of a 128-bit cache block.
//   block : 128-bit block, word 0 in bits [31:0]
//   sel   : word index within the block
//   word  : selected word (purely combinational)
module icache_word_select
    import instruction_cache_unit_pkg::*;
(
    input  logic [BLOCK_W-1:0]    block,
    input  logic [WORD_SEL_W-1:0] sel,
    output logic [WORD_W-1:0]     word
);

    always_comb begin
        word = block[WORD_W-1:0];
        case (sel)
            2'd0: word = block[31:0];
            2'd1: word = block[63:32];
            2'd2: word = block[95:64];
            2'd3: word = block[127:96];
            default: word = block[31:0];
        endcase
    end

endmodule

// File: rtl/instruction_cache_unit.sv
// Read-only direct-mapped instruction cache, 8 x 128-bit blocks.
// Hits return the instruction combinationally in the same cycle; a miss
// stalls the CPU, fetches the whole block from memory and refills the line.
//   CLK, RESET   : clock, synchronous active-high reset
//   bus (slave)  : CPU fetch and instruction memory signals
//   debug_state  : current controller state
module instruction_cache_unit
    import instruction_cache_unit_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RESET,
    instruction_cache_unit_if.slave bus,
    output state_t                  debug_state
);

    logic [TAG_W-1:0]      addr_tag;
    logic [INDEX_W-1:0]    addr_index;
    logic [WORD_SEL_W-1:0] addr_word;

    // Upper address bits alias into the 1 KB space; byte offset is ignored.
    logic unused_addr_bits;

    assign addr_tag         = bus.ADDRESS[9:7];
    assign addr_index       = bus.ADDRESS[6:4];
    assign addr_word        = bus.ADDRESS[3:2];
    assign unused_addr_bits = ^{bus.ADDRESS[31:10], bus.ADDRESS[1:0]};

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

    state_t state_q, state_d;
    logic   hit;
    logic   busywait;
    logic   mem_read;

    assign hit = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);

    icache_word_select u_word_select (
        .block (data_q[addr_index]),
        .sel   (addr_word),
        .word  (bus.INSTRUCTION)
    );

    always_comb begin
        state_d  = state_q;
        busywait = 1'b1;
        mem_read = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busywait = !hit;
                if (!hit) state_d = ST_MEM_READ;
            end
            ST_MEM_READ: begin
                mem_read = 1'b1;
                if (!bus.MEM_BUSYWAIT) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // The CPU holds ADDRESS during the stall, so the line being refilled is
    // still addressed by ADDRESS in UPDATE; MEM_READDATA is still driven then.
    always_ff @(posedge CLK) begin
        if (RESET)                     valid_q             <= '0;
        else if (state_q == ST_UPDATE) valid_q[addr_index] <= 1'b1;
    end

    // Tag and data need no reset: a cleared valid bit masks them.
    always_ff @(posedge CLK) begin
        if (!RESET && state_q == ST_UPDATE) begin
            tag_q[addr_index]  <= addr_tag;
            data_q[addr_index] <= bus.MEM_READDATA;
        end
    end

    assign bus.BUSYWAIT    = busywait;
    assign bus.MEM_READ    = mem_read;
    assign bus.MEM_ADDRESS = {addr_tag, addr_index};
    assign debug_state     = state_q;

endmodule

// File: tb/tb_instruction_cache_unit.sv
module tb_instruction_cache_unit;
    import instruction_cache_unit_pkg::*;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    instruction_cache_unit_if bus();
    state_t debug_state;

    instruction_cache_unit dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .bus         (bus),
        .debug_state (debug_state)
    );

    int checks = 0;
    int failures = 0;

    // ---------------- instruction memory model ----------------
    logic [127:0] mem_blocks [64];
    int mem_lat = 0;
    int mem_cnt = 0;
    int fill_count = 0;

    always @(posedge CLK) begin
        if (bus.MEM_READ) mem_cnt <= mem_cnt + 1;
        else              mem_cnt <= 0;
    end

    always @(posedge CLK) begin
        if (!RESET && bus.MEM_READ === 1'b1 && bus.MEM_BUSYWAIT === 1'b0)
            fill_count++;
    end

    assign bus.MEM_BUSYWAIT = bus.MEM_READ && (mem_cnt < mem_lat);
    assign bus.MEM_READDATA = mem_blocks[bus.MEM_ADDRESS];

    // ---------------- reference model ----------------
    // A block (ADDRESS[9:4]) is resident or not; a fill evicts every other
    // block that maps to the same line (block number modulo 8).
    bit resident [64];

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        logic [127:0] b;
        b = mem_blocks[a[9:4]];
        return b[32*a[3:2] +: 32];
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return resident[a[9:4]];
    endfunction

    function automatic void model_fill(input logic [31:0] a);
        for (int i = 0; i < 64; i++)
            if ((i % 8) == int'(a[6:4])) resident[i] = 1'b0;
        resident[a[9:4]] = 1'b1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) resident[i] = 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
    endtask

    // Presents an address and waits (bounded) until BUSYWAIT drops.
    task automatic do_fetch(input logic [31:0] a, output int edges,
                            output logic [5:0] req_addr, output bit saw_req);
        bus.ADDRESS = a;
        #1;
        edges = 0;
        saw_req = 1'b0;
        req_addr = '0;
        while (bus.BUSYWAIT !== 1'b0 && edges < 200) begin
            @(negedge CLK);
            edges++;
            if (bus.MEM_READ === 1'b1 && !saw_req) begin
                saw_req = 1'b1;
                req_addr = bus.MEM_ADDRESS;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] a;
        apply_reset();
        checks++;
        if (debug_state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d expected %0d", debug_state, ST_IDLE);
        end
        checks++;
        if (bus.MEM_READ !== 1'b0) begin
            failures++;
            $display("FAIL reset_mem_read: got %b expected 0", bus.MEM_READ);
        end
        for (int i = 0; i < 3; i++) begin
            a = $urandom();
            bus.ADDRESS = a;
            #1;
            checks++;
            if (bus.BUSYWAIT !== 1'b1) begin
                failures++;
                $display("FAIL reset_all_miss addr=%h: got %b expected 1", a, bus.BUSYWAIT);
            end
        end
    endtask

    task automatic test_first_fill();
        int edges, fc0;
        logic [5:0] ra;
        bit sr;
        mem_blocks[0] = 128'h44444444_33333333_22222222_11111111;
        mem_lat = 4;
        apply_reset();
        bus.ADDRESS = 32'h0;
        fc0 = fill_count;
        #1;
        checks++;
        if (bus.BUSYWAIT !== 1'b1) begin
            failures++;
            $display("FAIL fill_miss_busywait: got %b expected 1", bus.BUSYWAIT);
        end
        @(negedge CLK);
        checks++;
        if (bus.MEM_READ !== 1'b1 || bus.MEM_ADDRESS !== 6'h00) begin
            failures++;
            $display("FAIL fill_request: got rd=%b addr=%h expected rd=1 addr=00",
                     bus.MEM_READ, bus.MEM_ADDRESS);
        end
        do_fetch(32'h0, edges, ra, sr);
        checks++;
        if (bus.BUSYWAIT !== 1'b0 || edges + 1 != 3 + 4) begin
            failures++;
            $display("FAIL fill_latency: got busywait=%b edges=%0d expected 0 and 7",
                     bus.BUSYWAIT, edges + 1);
        end
        model_fill(32'h0);
        checks++;
        if (bus.INSTRUCTION !== 32'h11111111) begin
            failures++;
            $display("FAIL fill_word0: got %h expected 11111111", bus.INSTRUCTION);
        end
        checks++;
        if (fill_count != fc0 + 1) begin
            failures++;
            $display("FAIL fill_count: got %0d expected %0d", fill_count, fc0 + 1);
        end
    endtask

    task automatic test_word_hits();
        logic [31:0] addrs [3];
        logic [31:0] exp_w [3];
        int fc0;
        addrs[0] = 32'h4; addrs[1] = 32'h8; addrs[2] = 32'hC;
        exp_w[0] = 32'h22222222; exp_w[1] = 32'h33333333; exp_w[2] = 32'h44444444;
        fc0 = fill_count;
        for (int i = 0; i < 3; i++) begin
            bus.ADDRESS = addrs[i];
            #1;
            checks++;
            if (bus.BUSYWAIT !== 1'b0 || bus.INSTRUCTION !== exp_w[i]) begin
                failures++;
                $display("FAIL word_hit addr=%h: got bw=%b instr=%h expected bw=0 instr=%h",
                         addrs[i], bus.BUSYWAIT, bus.INSTRUCTION, exp_w[i]);
            end
            @(negedge CLK);
            checks++;
            if (bus.MEM_READ !== 1'b0) begin
                failures++;
                $display("FAIL word_hit_no_read addr=%h: got %b expected 0", addrs[i], bus.MEM_READ);
            end
        end
        checks++;
        if (fill_count != fc0) begin
            failures++;
            $display("FAIL word_hit_fills: got %0d expected %0d", fill_count, fc0);
        end
    endtask

    task automatic test_eviction();
        int edges, lat;
        logic [5:0] ra;
        bit sr;
        lat = $urandom_range(0, 3);
        mem_lat = lat;
        do_fetch(32'h080, edges, ra, sr);
        checks++;
        if (!sr || ra !== 6'h08) begin
            failures++;
            $display("FAIL evict_req_addr: got seen=%0d addr=%h expected 1 and 08", sr, ra);
        end
        checks++;
        if (bus.BUSYWAIT !== 1'b0 || edges != 3 + lat) begin
            failures++;
            $display("FAIL evict_latency: got bw=%b edges=%0d expected 0 and %0d",
                     bus.BUSYWAIT, edges, 3 + lat);
        end
        model_fill(32'h080);
        checks++;
        if (bus.INSTRUCTION !== imem_word(32'h080)) begin
            failures++;
            $display("FAIL evict_data: got %h expected %h", bus.INSTRUCTION, imem_word(32'h080));
        end
        bus.ADDRESS = 32'h0;
        #1;
        checks++;
        if (bus.BUSYWAIT !== !model_hit(32'h0)) begin
            failures++;
            $display("FAIL evict_old_miss: got %b expected %b", bus.BUSYWAIT, !model_hit(32'h0));
        end
        do_fetch(32'h0, edges, ra, sr);
        model_fill(32'h0);
        checks++;
        if (bus.BUSYWAIT !== 1'b0 || bus.INSTRUCTION !== 32'h11111111) begin
            failures++;
            $display("FAIL evict_refill: got bw=%b instr=%h expected 0 and 11111111",
                     bus.BUSYWAIT, bus.INSTRUCTION);
        end
    endtask

    task automatic test_reset_during_fill();
        int edges;
        logic [5:0] ra;
        bit sr;
        mem_lat = 1;
        do_fetch(32'h080, edges, ra, sr);
        model_fill(32'h080);
        mem_lat = 5;
        bus.ADDRESS = 32'h100;
        @(negedge CLK);
        checks++;
        if (bus.MEM_READ !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre_read: got %b expected 1", bus.MEM_READ);
        end
        apply_reset();
        checks++;
        if (bus.MEM_READ !== 1'b0 || debug_state !== ST_IDLE) begin
            failures++;
            $display("FAIL abort_state: got rd=%b state=%0d expected 0 and %0d",
                     bus.MEM_READ, debug_state, ST_IDLE);
        end
        bus.ADDRESS = 32'h080;
        #1;
        checks++;
        if (bus.BUSYWAIT !== 1'b1) begin
            failures++;
            $display("FAIL abort_valid_cleared: got %b expected 1", bus.BUSYWAIT);
        end
        mem_lat = 0;
        do_fetch(32'h080, edges, ra, sr);
        model_fill(32'h080);
    endtask

    task automatic test_alias();
        int edges;
        logic [5:0] ra;
        bit sr;
        mem_lat = 2;
        do_fetch(32'hFFFFFC10, edges, ra, sr);
        checks++;
        if (!sr || ra !== 6'h01 || edges != 5) begin
            failures++;
            $display("FAIL alias_fill: got seen=%0d addr=%h edges=%0d expected 1, 01, 5", sr, ra, edges);
        end
        model_fill(32'h010);
        checks++;
        if (bus.INSTRUCTION !== imem_word(32'h010)) begin
            failures++;
            $display("FAIL alias_data: got %h expected %h", bus.INSTRUCTION, imem_word(32'h010));
        end
        bus.ADDRESS = 32'h013;
        #1;
        checks++;
        if (bus.BUSYWAIT !== 1'b0 || bus.INSTRUCTION !== imem_word(32'h010)) begin
            failures++;
            $display("FAIL alias_low_hit: got bw=%b instr=%h expected 0 and %h",
                     bus.BUSYWAIT, bus.INSTRUCTION, imem_word(32'h010));
        end
        @(negedge CLK);
    endtask

    task automatic test_random();
        logic [31:0] a;
        int edges, lat, fc0;
        logic [5:0] ra;
        bit sr, exp_hit;
        for (int n = 0; n < 40; n++) begin
            a = $urandom();
            a[9:4] = 6'($urandom_range(0, 15));
            lat = $urandom_range(0, 4);
            mem_lat = lat;
            exp_hit = model_hit(a);
            fc0 = fill_count;
            bus.ADDRESS = a;
            #1;
            checks++;
            if (bus.BUSYWAIT !== !exp_hit) begin
                failures++;
                $display("FAIL rand_hit addr=%h: got bw=%b expected %b", a, bus.BUSYWAIT, !exp_hit);
            end
            do_fetch(a, edges, ra, sr);
            checks++;
            if (exp_hit ? (edges != 0 || fill_count != fc0)
                        : (edges != 3 + lat || ra !== a[9:4] || fill_count != fc0 + 1)) begin
                failures++;
                $display("FAIL rand_fill addr=%h: got edges=%0d req=%h fills=%0d expected hit=%0d lat=%0d",
                         a, edges, ra, fill_count - fc0, exp_hit, lat);
            end
            if (!exp_hit) model_fill(a);
            checks++;
            if (bus.BUSYWAIT !== 1'b0 || bus.INSTRUCTION !== imem_word(a)) begin
                failures++;
                $display("FAIL rand_data addr=%h: got bw=%b instr=%h expected 0 and %h",
                         a, bus.BUSYWAIT, bus.INSTRUCTION, imem_word(a));
            end
            @(negedge CLK);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.ADDRESS = 32'h0;
        for (int i = 0; i < 64; i++)
            mem_blocks[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        model_reset();
        test_reset();
        test_first_fill();
        test_word_hits();
        test_eviction();
        test_reset_during_fill();
        test_alias();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
